// File: rtl/rv32_dbus_target_if.sv
// rv32_dbus_target_if: core data bus on one side, downstream memory request bus on the other
interface rv32_dbus_target_if;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_address_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_fault_out;
  logic        data_stall_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_wmask_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;
  modport slave (
    input  data_read_in, data_write_in, data_write_mask_in, data_address_in, data_write_value_in,
    output data_read_value_out, data_fault_out, data_stall_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wmask_out,
    input  mem_ack_in, mem_rdata_in
  );
  modport master (
    output data_read_in, data_write_in, data_write_mask_in, data_address_in, data_write_value_in,
    input  data_read_value_out, data_fault_out, data_stall_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wmask_out,
    output mem_ack_in, mem_rdata_in
  );
endinterface

// File: rtl/rv32_dbus_target.sv
// rv32_dbus_target: bridges core data accesses inside an address window to a downstream ack-based bus
module rv32_dbus_target #(
  parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
  parameter int          SIZE_LOG2      = 16,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset_n,
  input logic               ce_i,
  rv32_dbus_target_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic        req;
  logic        hit;
  logic        expire;
  logic [31:0] off;
  logic [15:0] cnt_nxt;
  assign req     = bus.data_read_in | bus.data_write_in;
  assign off     = bus.data_address_in - BASE_ADDR;
  assign hit     = {1'b0, off} < (33'd1 << SIZE_LOG2);
  assign cnt_nxt = cnt + 16'd1;
  assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_nxt == 16'(TIMEOUT_CYCLES));
  assign bus.data_stall_out      = (state == BUSY) || (state == IDLE && req && hit);
  assign bus.data_fault_out      = state == IDLE ? req && !hit : state == DONE && req && fault_q;
  assign bus.data_read_value_out = state == DONE && req ? rdata_q : '0;
  // control FSM: latch the access, run it downstream until ack or timeout, present the result for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      fault_q           <= 1'b0;
      rdata_q           <= '0;
      bus.mem_req_out   <= 1'b0;
      bus.mem_we_out    <= 1'b0;
      bus.mem_addr_out  <= '0;
      bus.mem_wdata_out <= '0;
      bus.mem_wmask_out <= '0;
    end else if (ce_i) begin
      case (state)
        IDLE: if (req && hit) begin
          state             <= BUSY;
          cnt               <= '0;
          fault_q           <= 1'b0;
          rdata_q           <= '0;
          bus.mem_req_out   <= 1'b1;
          bus.mem_we_out    <= bus.data_write_in;
          bus.mem_addr_out  <= bus.data_address_in;
          bus.mem_wdata_out <= bus.data_write_in ? bus.data_write_value_in : '0;
          bus.mem_wmask_out <= bus.data_write_in ? bus.data_write_mask_in : '0;
        end
        BUSY: if (bus.mem_ack_in) begin
          rdata_q         <= bus.mem_we_out ? '0 : bus.mem_rdata_in;
          state           <= DONE;
          bus.mem_req_out <= 1'b0;
        end else if (expire) begin
          fault_q         <= 1'b1;
          state           <= DONE;
          bus.mem_req_out <= 1'b0;
        end else begin
          cnt <= cnt_nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_dbus_target.sv
// tb_rv32_dbus_target: directed vectors plus multi-cycle sequences for the data bus target
module tb_rv32_dbus_target;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ce = 1'b0;
  int   errors = 0;
  int   checks = 0;
  rv32_dbus_target_if bus ();
  rv32_dbus_target_if bus_t ();
  rv32_dbus_target dut (.clk(clk), .reset_n(reset_n), .ce_i(ce), .bus(bus));
  rv32_dbus_target #(.TIMEOUT_CYCLES(4)) dut_t (.clk(clk), .reset_n(reset_n), .ce_i(ce), .bus(bus_t));
  // free-running clock
  always #5 clk = ~clk;
  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wval;
    logic        stall;
    logic        fault;
  } vec_t;
  vec_t vecs [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic release_bus();
    bus.data_read_in = 1'b0;
    bus.data_write_in = 1'b0;
    tick();
  endtask
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wval,
                      input logic [3:0] mask, input int ack_at, input logic [31:0] adata,
                      output int stalls, output int busy, output int bad,
                      output logic [31:0] rv, output logic flt);
    bus.data_read_in = !wr;
    bus.data_write_in = wr;
    bus.data_address_in = addr;
    bus.data_write_value_in = wval;
    bus.data_write_mask_in = mask;
    stalls = 0;
    busy = 0;
    bad = 0;
    rv = 32'h0;
    flt = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!bus.data_stall_out) begin
        rv = bus.data_read_value_out;
        flt = bus.data_fault_out;
        return;
      end
      stalls++;
      if (bus.mem_req_out) begin
        busy++;
        if (bus.mem_we_out !== wr || bus.mem_addr_out !== addr ||
            bus.mem_wdata_out !== (wr ? wval : 32'h0) || bus.mem_wmask_out !== (wr ? mask : 4'h0))
          bad++;
      end
      bus.mem_ack_in = bus.mem_req_out && busy == ack_at;
      bus.mem_rdata_in = adata;
      @(posedge clk);
      #1;
      bus.mem_ack_in = 1'b0;
    end
  endtask
  // bound the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  // stimulus and checking
  initial begin
    int st, bz, bd, n;
    logic [31:0] rv;
    logic fl;
    bus.data_read_in = 1'b0; bus.data_write_in = 1'b0; bus.data_write_mask_in = 4'h0;
    bus.data_address_in = 32'h0; bus.data_write_value_in = 32'h0;
    bus.mem_ack_in = 1'b0; bus.mem_rdata_in = 32'h0;
    bus_t.data_read_in = 1'b0; bus_t.data_write_in = 1'b0; bus_t.data_write_mask_in = 4'h0;
    bus_t.data_address_in = 32'h0; bus_t.data_write_value_in = 32'h0;
    bus_t.mem_ack_in = 1'b0; bus_t.mem_rdata_in = 32'h0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst mem_req", bus.mem_req_out, 1'b0);
    chk("rst mem_we", bus.mem_we_out, 1'b0);
    chk("rst mem_addr", bus.mem_addr_out, 32'h0);
    chk("rst mem_wdata", bus.mem_wdata_out, 32'h0);
    chk("rst mem_wmask", bus.mem_wmask_out, 4'h0);
    chk("rst stall", bus.data_stall_out, 1'b0);
    #10 reset_n = 1'b1;
    tick();
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0001_0000, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'h0, 32'h0001_0004, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0001_0000, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 32'h0001_FFFC, 32'h0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h0002_0000, 32'h0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 4'h3, 32'h0001_8000, 32'h0000_BEEF, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bus.data_read_in = vecs[i].rd;
      bus.data_write_in = vecs[i].wr;
      bus.data_write_mask_in = vecs[i].mask;
      bus.data_address_in = vecs[i].addr;
      bus.data_write_value_in = vecs[i].wval;
      tick();
      chk($sformatf("vec%0d stall", i), bus.data_stall_out, vecs[i].stall);
      chk($sformatf("vec%0d fault", i), bus.data_fault_out, vecs[i].fault);
      chk($sformatf("vec%0d rvalue", i), bus.data_read_value_out, 32'h0);
      chk($sformatf("vec%0d mem_req", i), bus.mem_req_out, 1'b0);
    end
    release_bus();
    ce = 1'b1;
    xact(1'b0, 32'h0001_0004, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, st, bz, bd, rv, fl);
    chk("rd stall cycles", st, 2);
    chk("rd busy cycles", bz, 1);
    chk("rd fields", bd, 0);
    chk("rd value", rv, 32'hDEAD_BEEF);
    chk("rd fault", fl, 1'b0);
    chk("rd req drop", bus.mem_req_out, 1'b0);
    release_bus();
    xact(1'b1, 32'h0001_FFFC, 32'h00AB_0000, 4'b0100, 5, 32'hFFFF_FFFF, st, bz, bd, rv, fl);
    chk("wr stall cycles", st, 6);
    chk("wr busy cycles", bz, 5);
    chk("wr fields", bd, 0);
    chk("wr value", rv, 32'h0);
    chk("wr fault", fl, 1'b0);
    release_bus();
    xact(1'b0, 32'h0002_0000, 32'h0, 4'h0, 1, 32'h0, st, bz, bd, rv, fl);
    chk("oow stall cycles", st, 0);
    chk("oow fault", fl, 1'b1);
    chk("oow mem_req", bus.mem_req_out, 1'b0);
    release_bus();
    chk("oow mem_req later", bus.mem_req_out, 1'b0);
    xact(1'b0, 32'h0001_0000, 32'h0, 4'h0, 1, 32'h1111_1111, st, bz, bd, rv, fl);
    chk("b2b first value", rv, 32'h1111_1111);
    bus.data_address_in = 32'h0001_0008;
    tick();
    chk("b2b idle stall", bus.data_stall_out, 1'b1);
    chk("b2b idle mem_req", bus.mem_req_out, 1'b0);
    tick();
    chk("b2b busy mem_req", bus.mem_req_out, 1'b1);
    chk("b2b busy addr", bus.mem_addr_out, 32'h0001_0008);
    bus.mem_ack_in = 1'b1;
    bus.mem_rdata_in = 32'h2222_2222;
    tick();
    bus.mem_ack_in = 1'b0;
    chk("b2b second value", bus.data_read_value_out, 32'h2222_2222);
    chk("b2b second stall", bus.data_stall_out, 1'b0);
    release_bus();
    bus.data_read_in = 1'b1;
    bus.data_address_in = 32'h0001_0010;
    tick();
    bus.data_read_in = 1'b0;
    #1;
    chk("drop busy mem_req", bus.mem_req_out, 1'b1);
    chk("drop busy stall", bus.data_stall_out, 1'b1);
    bus.mem_ack_in = 1'b1;
    bus.mem_rdata_in = 32'h5555_5555;
    tick();
    bus.mem_ack_in = 1'b0;
    chk("drop done value", bus.data_read_value_out, 32'h0);
    chk("drop done fault", bus.data_fault_out, 1'b0);
    chk("drop done mem_req", bus.mem_req_out, 1'b0);
    tick();
    chk("drop idle mem_req", bus.mem_req_out, 1'b0);
    bus_t.data_read_in = 1'b1;
    bus_t.data_address_in = 32'h0001_0000;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!bus_t.data_stall_out) break;
      n++;
      tick();
    end
    chk("to stall cycles", n, 5);
    chk("to fault", bus_t.data_fault_out, 1'b1);
    chk("to value", bus_t.data_read_value_out, 32'h0);
    chk("to mem_req", bus_t.mem_req_out, 1'b0);
    bus_t.data_read_in = 1'b0;
    tick();
    tick();
    bus_t.mem_ack_in = 1'b1;
    bus_t.mem_rdata_in = 32'h9999_9999;
    #1;
    chk("late ack stall", bus_t.data_stall_out, 1'b0);
    chk("late ack fault", bus_t.data_fault_out, 1'b0);
    tick();
    bus_t.mem_ack_in = 1'b0;
    chk("late ack mem_req", bus_t.mem_req_out, 1'b0);
    bus_t.data_read_in = 1'b1;
    bus_t.data_address_in = 32'h0001_0004;
    tick();
    chk("after to mem_req", bus_t.mem_req_out, 1'b1);
    bus_t.mem_ack_in = 1'b1;
    bus_t.mem_rdata_in = 32'h7777_7777;
    tick();
    bus_t.mem_ack_in = 1'b0;
    chk("after to fault", bus_t.data_fault_out, 1'b0);
    chk("after to value", bus_t.data_read_value_out, 32'h7777_7777);
    bus_t.data_read_in = 1'b0;
    tick();
    bus.data_read_in = 1'b1;
    bus.data_address_in = 32'h0001_0020;
    tick();
    chk("rstb busy mem_req", bus.mem_req_out, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstb mem_req", bus.mem_req_out, 1'b0);
    chk("rstb mem_addr", bus.mem_addr_out, 32'h0);
    ce = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("ce0 mem_req", bus.mem_req_out, 1'b0);
    chk("ce0 mem_addr", bus.mem_addr_out, 32'h0);
    chk("ce0 mem_we", bus.mem_we_out, 1'b0);
    chk("ce0 value", bus.data_read_value_out, 32'h0);
    chk("ce0 fault", bus.data_fault_out, 1'b0);
    ce = 1'b1;
    tick();
    chk("ce1 mem_req", bus.mem_req_out, 1'b1);
    chk("ce1 mem_addr", bus.mem_addr_out, 32'h0001_0020);
    bus.mem_ack_in = 1'b1;
    bus.mem_rdata_in = 32'hABCD_0123;
    tick();
    bus.mem_ack_in = 1'b0;
    chk("ce1 value", bus.data_read_value_out, 32'hABCD_0123);
    release_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
